// File: rtl/card_dispenser.sv
// Deck sequencer: starts the shuffler, loads a full deck of distinct cards, then serves
// round-robin draw requests from the player and dealer hands through one read port.
module card_dispenser #(
  parameter int unsigned DeckSize = 52,
  parameter int unsigned CardW    = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             new_deck_i,
  output logic             shuf_start_o,
  input  logic             shuf_valid_i,
  input  logic [CardW-1:0] shuf_card_i,
  output logic             shuf_ready_o,
  input  logic             req_player_i,
  input  logic             req_dealer_i,
  output logic             gnt_player_o,
  output logic             gnt_dealer_o,
  output logic [CardW-1:0] card_o,
  output logic [3:0]       card_value_o,
  output logic [5:0]       remaining_o,
  output logic             deck_ready_o,
  output logic             empty_o,
  output logic             load_err_o
);

  localparam int unsigned PtrW = $clog2(DeckSize + 1);

  typedef enum logic [2:0] {
    StIdle,
    StShufReq,
    StLoad,
    StReady,
    StFetch,
    StGrant
  } state_e;

  state_e                 state_q, state_d;
  logic [2**CardW-1:0]    seen_q, seen_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [5:0]             remaining_q, remaining_d;
  logic                   load_err_q, load_err_d;
  // 1 = dealer; reset to dealer so the player wins the first tie
  logic                   last_gnt_q, last_gnt_d;
  logic                   win_q, win_d;
  logic [CardW-1:0]       card_q, card_d;
  logic                   card_vld_q, card_vld_d;
  logic                   deck_we;
  logic                   card_ok;
  logic                   tie_dealer;
  logic [CardW-1:0]       deck_q [DeckSize];
  logic [CardW-1:0]       idx;

  assign card_ok    = (shuf_card_i < CardW'(DeckSize)) && !seen_q[shuf_card_i];
  assign tie_dealer = req_player_i && req_dealer_i ? ~last_gnt_q : req_dealer_i;

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    load_err_d  = load_err_q;
    last_gnt_d  = last_gnt_q;
    win_d       = win_q;
    card_d      = card_q;
    card_vld_d  = card_vld_q;
    deck_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (new_deck_i) state_d = StShufReq;
      end
      StShufReq: begin
        seen_d      = '0;
        wr_ptr_d    = '0;
        remaining_d = '0;
        load_err_d  = 1'b0;
        state_d     = StLoad;
      end
      StLoad: begin
        if (shuf_valid_i) begin
          if (card_ok) begin
            deck_we              = 1'b1;
            seen_d[shuf_card_i]  = 1'b1;
            wr_ptr_d             = wr_ptr_q + 1'b1;
            remaining_d          = remaining_q + 6'd1;
            if (wr_ptr_q == PtrW'(DeckSize - 1)) begin
              rd_ptr_d = '0;
              state_d  = StReady;
            end
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      StReady: begin
        // a reload request beats any pending draw
        if (new_deck_i) begin
          state_d = StShufReq;
        end else if ((remaining_q != 6'd0) && (req_player_i || req_dealer_i)) begin
          win_d      = tie_dealer;
          last_gnt_d = tie_dealer;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        card_d      = deck_q[rd_ptr_q];
        card_vld_d  = 1'b1;
        rd_ptr_d    = rd_ptr_q + 1'b1;
        remaining_d = remaining_q - 6'd1;
        state_d     = StGrant;
      end
      StGrant: begin
        state_d = StReady;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      seen_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      load_err_q  <= 1'b0;
      last_gnt_q  <= 1'b1;
      win_q       <= 1'b0;
      card_q      <= '0;
      card_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      load_err_q  <= load_err_d;
      last_gnt_q  <= last_gnt_d;
      win_q       <= win_d;
      card_q      <= card_d;
      card_vld_q  <= card_vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (deck_we) deck_q[wr_ptr_q] <= shuf_card_i;
  end

  // card_value reads 0 until the first card has been drawn since reset
  assign idx = card_q % CardW'(13);
  always_comb begin
    card_value_o = 4'd0;
    if (card_vld_q) begin
      if (idx == '0)            card_value_o = 4'd1;
      else if (idx >= CardW'(9)) card_value_o = 4'd10;
      else                       card_value_o = 4'(idx + 1'b1);
    end
  end

  assign shuf_start_o = (state_q == StShufReq);
  assign shuf_ready_o = (state_q == StLoad);
  assign gnt_player_o = (state_q == StGrant) && !win_q;
  assign gnt_dealer_o = (state_q == StGrant) && win_q;
  assign card_o       = card_q;
  assign remaining_o  = remaining_q;
  assign deck_ready_o = (state_q == StReady);
  assign empty_o      = (state_q == StReady) && (remaining_q == 6'd0);
  assign load_err_o   = load_err_q;

endmodule

// File: tb/tb_card_dispenser.sv
// Bench for card_dispenser: randomised loads and draws checked against a queue-based deck model.
module tb_card_dispenser;

  logic       clk;
  logic       rst;
  logic       new_deck;
  logic       shuf_start;
  logic       shuf_valid;
  logic [5:0] shuf_card;
  logic       shuf_ready;
  logic       req_player;
  logic       req_dealer;
  logic       gnt_player;
  logic       gnt_dealer;
  logic [5:0] card;
  logic [3:0] card_value;
  logic [5:0] remaining;
  logic       deck_ready;
  logic       empty;
  logic       load_err;

  card_dispenser #(
    .DeckSize(52),
    .CardW   (6)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .new_deck_i  (new_deck),
    .shuf_start_o(shuf_start),
    .shuf_valid_i(shuf_valid),
    .shuf_card_i (shuf_card),
    .shuf_ready_o(shuf_ready),
    .req_player_i(req_player),
    .req_dealer_i(req_dealer),
    .gnt_player_o(gnt_player),
    .gnt_dealer_o(gnt_dealer),
    .card_o      (card),
    .card_value_o(card_value),
    .remaining_o (remaining),
    .deck_ready_o(deck_ready),
    .empty_o     (empty),
    .load_err_o  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model of the deck contents and arbitration history
  int        mdeck[$];
  bit [63:0] mseen;
  int        mrd;
  int        mrem;
  bit        merr;
  bit        mlast_dealer;
  int        mcard;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int val_of(input int c);
    int r;
    r = c % 13;
    if (r == 0) return 1;
    if (r >= 9) return 10;
    return r + 1;
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, "_shuf_start"}, shuf_start, 0);
    chk({pfx, "_shuf_ready"}, shuf_ready, 0);
    chk({pfx, "_gnt_player"}, gnt_player, 0);
    chk({pfx, "_gnt_dealer"}, gnt_dealer, 0);
    chk({pfx, "_card"}, card, 0);
    chk({pfx, "_card_value"}, card_value, 0);
    chk({pfx, "_remaining"}, remaining, 0);
    chk({pfx, "_deck_ready"}, deck_ready, 0);
    chk({pfx, "_empty"}, empty, 0);
    chk({pfx, "_load_err"}, load_err, 0);
  endtask

  // All driving and sampling happens at the falling edge.
  task automatic load_deck(input bit junk, input bit with_req);
    int perm[52];
    int offers[$];
    int cyc;
    int c;
    bit v;
    for (int i = 0; i < 52; i++) perm[i] = i;
    for (int i = 51; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    if (!junk) begin
      for (int i = 0; i < 52; i++) offers.push_back(51 - i);
    end else begin
      offers.push_back(5); offers.push_back(5); offers.push_back(60);
      for (int i = 0; i < 52; i++) begin
        if ($urandom_range(0, 7) == 0)
          offers.push_back($urandom_range(0, 1) ? 52 + $urandom_range(0, 11) : 5);
        if (perm[i] != 5) offers.push_back(perm[i]);
      end
    end
    new_deck = 1'b1;
    req_player = with_req;
    req_dealer = with_req;
    @(negedge clk);
    new_deck = 1'b0;
    req_player = 1'b0;
    req_dealer = 1'b0;
    chk("shuf_start", shuf_start, 1);
    chk("shufreq_gnt", gnt_player | gnt_dealer, 0);
    mdeck.delete();
    mseen = '0;
    mrd = 0;
    mrem = 0;
    merr = 1'b0;
    @(negedge clk);
    chk("load_shuf_ready", shuf_ready, 1);
    chk("load_start_remaining", remaining, 0);
    chk("load_start_err", load_err, 0);
    cyc = 0;
    while (mdeck.size() < 52 && cyc < 400) begin
      v = (offers.size() != 0) && !(junk && $urandom_range(0, 7) == 0);
      c = v ? offers.pop_front() : 0;
      shuf_valid = v;
      shuf_card = 6'(c);
      @(negedge clk);
      cyc++;
      if (v) begin
        if (c < 52 && !mseen[c]) begin
          mseen[c] = 1'b1;
          mdeck.push_back(c);
          mrem++;
        end else begin
          merr = 1'b1;
        end
      end
      chk("load_remaining", remaining, mrem);
      chk("load_err", load_err, merr);
    end
    shuf_valid = 1'b0;
    if (mdeck.size() != 52) begin
      vectors++;
      errors++;
      $display("FAIL load_timeout: observed %0d cards expected 52", mdeck.size());
    end
    chk("loaded_deck_ready", deck_ready, 1);
    chk("loaded_shuf_ready", shuf_ready, 0);
    chk("loaded_empty", empty, 0);
  endtask

  // Called at a falling edge while the DUT is in READY with cards left.
  task automatic draw(input bit p, input bit d, input bit drop, input bit scramble);
    bit wd;
    int c;
    chk("pre_ready", deck_ready, 1);
    req_player = p;
    req_dealer = d;
    wd = (p && d) ? !mlast_dealer : d;
    @(negedge clk);
    chk("fetch_gnt_player", gnt_player, 0);
    chk("fetch_gnt_dealer", gnt_dealer, 0);
    if (scramble) begin
      req_player = 1'($urandom);
      req_dealer = 1'($urandom);
    end
    @(negedge clk);
    c = mdeck[mrd];
    mrd++;
    mrem--;
    mlast_dealer = wd;
    mcard = c;
    chk("gnt_player", gnt_player, !wd);
    chk("gnt_dealer", gnt_dealer, wd);
    chk("card", card, c);
    chk("card_value", card_value, val_of(c));
    chk("gnt_remaining", remaining, mrem);
    if (scramble) begin
      req_player = 1'b0;
      req_dealer = 1'b0;
    end else if (drop) begin
      if (wd) req_dealer = 1'b0;
      else    req_player = 1'b0;
    end
    @(negedge clk);
    chk("back_ready", deck_ready, 1);
    chk("empty", empty, mrem == 0);
    chk("ready_no_gnt", gnt_player | gnt_dealer, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    rst = 1'b1;
    new_deck = 1'b0;
    shuf_valid = 1'b0;
    shuf_card = '0;
    req_player = 1'b0;
    req_dealer = 1'b0;
    mlast_dealer = 1'b1;
    mrem = 0;
    mcard = 0;
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Clean descending load, then a lone player draw takes card 51
    load_deck(1'b0, 1'b0);
    draw(1'b1, 1'b0, 1'b1, 1'b0);
    chk("first_card", card, 51);

    // Both held: grants alternate every 3 cycles
    for (int i = 0; i < 4; i++) draw(1'b1, 1'b1, 1'b0, 1'b0);
    req_player = 1'b0;
    req_dealer = 1'b0;

    // Random traffic until the deck is empty
    guard = 0;
    while (mrem > 0 && guard < 400) begin
      bit p;
      bit d;
      guard++;
      p = 1'($urandom);
      d = 1'($urandom);
      if (p || d) begin
        draw(p, d, 1'b1, 1'($urandom));
      end else begin
        req_player = 1'b0;
        req_dealer = 1'b0;
        @(negedge clk);
        chk("idle_no_gnt", gnt_player | gnt_dealer, 0);
        chk("idle_remaining", remaining, mrem);
        chk("card_hold", card, mcard);
      end
    end
    chk("drained_remaining", remaining, mrem);
    chk("drained_empty", empty, 1);
    req_player = 1'b1;
    req_dealer = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("empty_no_gnt", gnt_player | gnt_dealer, 0);
      chk("empty_hold", empty, 1);
    end
    req_player = 1'b0;
    req_dealer = 1'b0;

    // Reload with a duplicate, out-of-range cards and bubbles
    load_deck(1'b1, 1'b0);
    draw(1'b0, 1'b1, 1'b1, 1'b0);

    // Reset while fetching
    req_player = 1'b1;
    @(negedge clk);
    chk("pre_rst_fetch", gnt_player | gnt_dealer, 0);
    rst = 1'b1;
    req_player = 1'b0;
    @(negedge clk);
    chk_zero("rst_fetch");
    mlast_dealer = 1'b1;
    mrem = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_start", shuf_start, 0);
    chk("post_rst_idle_ready", deck_ready, 0);

    // After reset the player wins a tie
    load_deck(1'b1, 1'b0);
    draw(1'b1, 1'b1, 1'b1, 1'b0);
    req_player = 1'b0;
    req_dealer = 1'b0;

    // new_deck beats pending requests in READY
    load_deck(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
